cnn_run_sequencer: RTL and testbench

CNN_RUN_SEQUENCER -- requirements
Module: cnn_run_sequencer

---
 rtl/cnn_ctrl_pkg.sv | 17 +
 rtl/cnn_timeout_cnt.sv | 33 +++
 rtl/cnn_run_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cnn_run_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared types and defaults for the CNN accelerator batch run sequencer.
// Holds the sequencer state encoding and default parameter values.
package cnn_ctrl_pkg;

  localparam int          DEF_CNT_W   = 16;
  localparam int unsigned DEF_TIMEOUT = 24'd1000000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ACK  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/cnn_timeout_cnt.sv
// Per-phase watchdog: counts enabled cycles, flags tc when count reaches TIMEOUT-1.
// tc is combinational from the count register; TIMEOUT of 0 never flags.
module cnn_timeout_cnt
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned    CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic           ARMED = (TIMEOUT != 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && ARMED) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = ARMED && enable && (cnt == LAST);

endmodule

// File: rtl/cnn_run_sequencer.sv
// Batch sequencer: issues num_runs start/finished handshakes to the accelerator, with timeout and abort.
// acc_start rises the cycle after command accept; commands are taken only while idle (cmd_ready).
module cnn_run_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int          CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_num_runs,
  input  logic             cmd_new_weights,
  input  logic             abort,
  output logic             acc_start,
  output logic             acc_same_w,
  output logic             acc_finished_ok,
  input  logic             acc_finished,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] runs_done
);

  seq_state_t       state;
  logic [CNT_W-1:0] num_runs;
  logic             new_weights;
  logic [CNT_W-1:0] runs_inc;
  logic             tmo_en;
  logic             tmo_clr;
  logic             tmo_tc;

  assign runs_inc = runs_done + CNT_W'(1);

  // Counter sits at zero outside REQ/ACK and restarts on the REQ->ACK hop.
  assign tmo_en  = (state == ST_REQ) || (state == ST_ACK);
  assign tmo_clr = !tmo_en || ((state == ST_REQ) && acc_finished);

  cnn_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .clear  (tmo_clr),
    .enable (tmo_en),
    .tc     (tmo_tc)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state           <= ST_IDLE;
      num_runs        <= '0;
      new_weights     <= 1'b0;
      cmd_ready       <= 1'b0;
      acc_start       <= 1'b0;
      acc_same_w      <= 1'b0;
      acc_finished_ok <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      runs_done       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_ready && cmd_valid && !abort) begin
            cmd_ready   <= 1'b0;
            num_runs    <= cmd_num_runs;
            new_weights <= cmd_new_weights;
            runs_done   <= '0;
            error       <= 1'b0;
            busy        <= 1'b1;
            if (cmd_num_runs != '0) begin
              state      <= ST_REQ;
              acc_start  <= 1'b1;
              acc_same_w <= !cmd_new_weights;
            end else begin
              state <= ST_DONE;
            end
          end
        end

        ST_REQ: begin
          if (abort) begin
            state           <= ST_IDLE;
            acc_start       <= 1'b0;
            acc_same_w      <= 1'b0;
            acc_finished_ok <= 1'b0;
            busy            <= 1'b0;
            cmd_ready       <= 1'b1;
          end else if (acc_finished) begin
            state           <= ST_ACK;
            acc_start       <= 1'b0;
            acc_finished_ok <= 1'b1;
          end else if (tmo_tc) begin
            state           <= ST_ERR;
            acc_start       <= 1'b0;
            acc_same_w      <= 1'b0;
            acc_finished_ok <= 1'b0;
            error           <= 1'b1;
            busy            <= 1'b0;
          end
        end

        ST_ACK: begin
          if (abort) begin
            state           <= ST_IDLE;
            acc_start       <= 1'b0;
            acc_same_w      <= 1'b0;
            acc_finished_ok <= 1'b0;
            busy            <= 1'b0;
            cmd_ready       <= 1'b1;
          end else if (!acc_finished) begin
            acc_finished_ok <= 1'b0;
            acc_same_w      <= 1'b0;
            runs_done       <= runs_inc;
            state           <= (runs_inc == num_runs) ? ST_DONE : ST_GAP;
          end else if (tmo_tc) begin
            state           <= ST_ERR;
            acc_start       <= 1'b0;
            acc_same_w      <= 1'b0;
            acc_finished_ok <= 1'b0;
            error           <= 1'b1;
            busy            <= 1'b0;
          end
        end

        ST_GAP: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            state      <= ST_REQ;
            acc_start  <= 1'b1;
            acc_same_w <= !((runs_done == '0) && new_weights);
          end
        end

        ST_DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        ST_ERR: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_run_sequencer.sv
// Directed bench for cnn_run_sequencer with an accelerator responder and a start/done scoreboard.
module tb_cnn_run_sequencer;

  localparam int CW = 8;

  logic          clk_clk;
  logic          reset_reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_num_runs;
  logic          cmd_new_weights;
  logic          abort;
  logic          acc_start;
  logic          acc_same_w;
  logic          acc_finished_ok;
  logic          acc_finished;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] runs_done;

  int n_assert = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_done   = 0;

  // 0: timed responder, 1: never finishes, 2: driven by the main sequence
  int acc_mode   = 0;
  int fin_delay  = 5;
  int drop_delay = 2;
  int rsp_sc     = 0;
  int rsp_oc     = 0;

  logic          exp_sw_q[$];
  logic [CW-1:0] exp_rd_q[$];
  logic          prev_start = 1'b0;
  logic          cur_sw     = 1'b0;

  cnn_run_sequencer #(
    .CNT_W   (CW),
    .TIMEOUT (16)
  ) dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_num_runs    (cmd_num_runs),
    .cmd_new_weights (cmd_new_weights),
    .abort           (abort),
    .acc_start       (acc_start),
    .acc_same_w      (acc_same_w),
    .acc_finished_ok (acc_finished_ok),
    .acc_finished    (acc_finished),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .runs_done       (runs_done)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accelerator model: raises finished after fin_delay start cycles, drops it drop_delay cycles into finished_ok.
  initial begin
    acc_finished = 1'b0;
    forever begin
      @(negedge clk_clk);
      if (acc_mode != 2) begin
        if (acc_finished && !busy) begin
          acc_finished = 1'b0;
          rsp_sc = 0;
          rsp_oc = 0;
        end else if (acc_mode == 0 && !acc_finished) begin
          if (acc_start) begin
            rsp_sc++;
            if (rsp_sc >= fin_delay) begin
              acc_finished = 1'b1;
              rsp_sc = 0;
            end
          end else begin
            rsp_sc = 0;
          end
        end else if (acc_mode == 0 && acc_finished && acc_finished_ok) begin
          rsp_oc++;
          if (rsp_oc >= drop_delay) begin
            acc_finished = 1'b0;
            rsp_oc = 0;
          end
        end
      end
    end
  end

  // Scoreboard: pops expected same_w on each start rise and expected runs_done on each done pulse.
  initial forever begin
    @(negedge clk_clk);
    if (acc_start === 1'b1 && prev_start !== 1'b1) begin
      n_start++;
      chk("start_expected", exp_sw_q.size() > 0, 1);
      if (exp_sw_q.size() > 0) begin
        cur_sw = exp_sw_q.pop_front();
        chk("same_w_at_start", acc_same_w, cur_sw);
      end
    end else if (acc_start === 1'b1) begin
      chk("same_w_stable", acc_same_w, cur_sw);
    end
    if (done === 1'b1) begin
      n_done++;
      chk("done_expected", exp_rd_q.size() > 0, 1);
      if (exp_rd_q.size() > 0) chk("runs_done_at_done", runs_done, exp_rd_q.pop_front());
    end
    prev_start = acc_start;
  end

  task automatic send(input logic [CW-1:0] nr, input logic nw);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk_clk);
      t++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid       = 1'b1;
    cmd_num_runs    = nr;
    cmd_new_weights = nw;
    @(negedge clk_clk);
    cmd_valid = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_start_latency", acc_start, (nr != 0));
    chk("accept_runs_done_clr", runs_done, 0);
    chk("accept_error_clr", error, 0);
    chk("accept_cmd_ready_low", cmd_ready, 0);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy === 1'b1 && t < budget) begin
      @(negedge clk_clk);
      t++;
    end
    chk("idle_within_budget", (t < budget), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_acc_start"}, acc_start, 0);
    chk({tag, "_acc_same_w"}, acc_same_w, 0);
    chk({tag, "_acc_finished_ok"}, acc_finished_ok, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_runs_done"}, runs_done, 0);
  endtask

  initial begin
    int d0;
    int s0;
    int t;
    int n_hi;
    cmd_valid       = 1'b0;
    cmd_num_runs    = '0;
    cmd_new_weights = 1'b0;
    abort           = 1'b0;
    reset_reset_n   = 1'b0;
    repeat (3) @(negedge clk_clk);
    chk_reset_vals("reset");
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // abort wins over a coincident command in IDLE
    cmd_valid    = 1'b1;
    cmd_num_runs = 8'd3;
    abort        = 1'b1;
    @(negedge clk_clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_cmd_ready", cmd_ready, 1);
    chk("idle_abort_start", acc_start, 0);

    // three runs with weight reload on the first
    acc_mode = 0; fin_delay = 5; drop_delay = 2;
    exp_sw_q.push_back(1'b0); exp_sw_q.push_back(1'b1); exp_sw_q.push_back(1'b1);
    exp_rd_q.push_back(8'd3);
    d0 = n_done; s0 = n_start;
    send(8'd3, 1'b1);
    wait_idle(300);
    @(negedge clk_clk);
    chk("b3_done_count", n_done - d0, 1);
    chk("b3_start_count", n_start - s0, 3);
    chk("b3_done_single_cycle", done, 0);
    chk("b3_runs_done", runs_done, 3);
    chk("b3_error", error, 0);

    // zero-run batch
    exp_rd_q.push_back(8'd0);
    s0 = n_start;
    send(8'd0, 1'b0);
    chk("zero_done_not_early", done, 0);
    @(negedge clk_clk);
    chk("zero_done_pulse", done, 1);
    chk("zero_busy_low", busy, 0);
    @(negedge clk_clk);
    chk("zero_done_drop", done, 0);
    chk("zero_cmd_ready", cmd_ready, 1);
    chk("zero_runs_done", runs_done, 0);
    chk("zero_no_start", n_start - s0, 0);

    // accelerator never finishes: timeout after 16 REQ cycles
    acc_mode = 1;
    exp_sw_q.push_back(1'b1);
    d0 = n_done;
    send(8'd1, 1'b0);
    n_hi = 0; t = 0;
    while (acc_start === 1'b1 && t < 100) begin
      n_hi++;
      @(negedge clk_clk);
      t++;
    end
    chk("tmo_start_cycles", n_hi, 16);
    chk("tmo_error", error, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_finished_ok", acc_finished_ok, 0);
    @(negedge clk_clk);
    chk("tmo_error_sticky", error, 1);
    chk("tmo_cmd_ready", cmd_ready, 1);
    chk("tmo_no_done", n_done - d0, 0);
    acc_mode = 0;
    exp_sw_q.push_back(1'b1);
    exp_rd_q.push_back(8'd1);
    send(8'd1, 1'b0);
    wait_idle(100);
    @(negedge clk_clk);
    chk("post_tmo_done_count", n_done - d0, 1);

    // abort during ACK of run 2 of 4
    exp_sw_q.push_back(1'b0); exp_sw_q.push_back(1'b1);
    s0 = n_start; d0 = n_done;
    send(8'd4, 1'b1);
    t = 0;
    while (!((n_start - s0) == 2 && acc_finished_ok === 1'b1) && t < 200) begin
      @(negedge clk_clk);
      t++;
    end
    chk("abort_point_reached", (t < 200), 1);
    abort = 1'b1;
    @(negedge clk_clk);
    abort = 1'b0;
    chk("abort_start", acc_start, 0);
    chk("abort_finished_ok", acc_finished_ok, 0);
    chk("abort_same_w", acc_same_w, 0);
    chk("abort_busy", busy, 0);
    chk("abort_runs_done", runs_done, 1);
    chk("abort_error", error, 0);
    repeat (10) @(negedge clk_clk);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_no_more_starts", n_start - s0, 2);

    // reset pulse during REQ, then a clean batch
    exp_sw_q.push_back(1'b0);
    send(8'd2, 1'b1);
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    chk_reset_vals("midreset");
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("midreset_cmd_ready", cmd_ready, 1);
    exp_sw_q.push_back(1'b1); exp_sw_q.push_back(1'b1);
    exp_rd_q.push_back(8'd2);
    d0 = n_done;
    send(8'd2, 1'b0);
    wait_idle(200);
    @(negedge clk_clk);
    chk("post_reset_runs_done", runs_done, 2);
    chk("post_reset_done_count", n_done - d0, 1);

    // finished coincident with timeout terminal count
    acc_mode = 2;
    exp_sw_q.push_back(1'b1);
    exp_rd_q.push_back(8'd1);
    d0 = n_done;
    send(8'd1, 1'b0);
    repeat (15) @(negedge clk_clk);
    chk("tc_still_req", acc_start, 1);
    acc_finished = 1'b1;
    @(negedge clk_clk);
    chk("tc_ack_finished_ok", acc_finished_ok, 1);
    chk("tc_ack_start_low", acc_start, 0);
    chk("tc_ack_error", error, 0);
    acc_finished = 1'b0;
    @(negedge clk_clk);
    chk("tc_runs_done", runs_done, 1);
    chk("tc_finished_ok_drop", acc_finished_ok, 0);
    wait_idle(50);
    @(negedge clk_clk);
    chk("tc_error_final", error, 0);
    chk("tc_done_count", n_done - d0, 1);

    // maximum batch for the counter width, with a stray command mid-batch
    acc_mode = 0; fin_delay = 1; drop_delay = 1;
    exp_sw_q.push_back(1'b0);
    for (int i = 1; i < 255; i++) exp_sw_q.push_back(1'b1);
    exp_rd_q.push_back(8'd255);
    d0 = n_done; s0 = n_start;
    send(8'd255, 1'b1);
    repeat (3) @(negedge clk_clk);
    cmd_valid    = 1'b1;
    cmd_num_runs = 8'd2;
    @(negedge clk_clk);
    cmd_valid = 1'b0;
    chk("busy_cmd_ready_low", cmd_ready, 0);
    wait_idle(3000);
    @(negedge clk_clk);
    chk("max_runs_done", runs_done, 255);
    chk("max_start_count", n_start - s0, 255);
    chk("max_done_count", n_done - d0, 1);
    chk("max_error", error, 0);

    chk("sw_queue_drained", exp_sw_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
